planificador_sensores: RTL and testbench

- Scan scheduler that time-shares one temperature monitoring datapath among N_CANALES sensors.
- Every PERIODO idle cycles it walks channels 0..N-1 and forwards each valid sample to the datapath.
- After a fixed result latency it captures the datapath alert into a per-channel status bit.
- It also flags sensors that miss MAX_FALTAS consecutive scans.
- It sits between the sensor front-ends and the monitoring top-level.

---
 rtl/planificador_sensores_pkg.sv | 19 +
 rtl/planificador_sensores_contador_faltas.sv | 48 ++++
 rtl/planificador_sensores.sv | 204 ++++++++++++++++++++
 tb/tb_planificador_sensores.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/planificador_sensores_pkg.sv
// rtl/planificador_sensores_pkg.sv - shared types for the sensor scan scheduler
// Purpose: default sample width, scheduler state encoding and the signed sample type.
// Ports: none (package).
package pkg_monitoreo;

    localparam int ANCHO_TEMP_DEF = 11;

    typedef enum logic [2:0] {
        REPOSO,
        ESPERA,
        SELECCION,
        ENVIO,
        ESPERA_RES,
        CAPTURA
    } estado_plan_t;

    typedef logic signed [ANCHO_TEMP_DEF-1:0] temp_t;

endpackage

// File: rtl/planificador_sensores_contador_faltas.sv
// rtl/planificador_sensores_contador_faltas.sv - saturating missed-scan counter for one channel
// Purpose: counts consecutive skipped scans of one sensor and raises a fault flag at the limit.
// Ports:
//   clk, arst_n : clock, synchronous active-low reset
//   inc_i       : channel skipped this scan (counter saturates at MAX_FALTAS)
//   clr_i       : good sample consumed, clears count and fault (wins over inc_i)
//   falla_o     : registered fault flag
module contador_faltas #(
    parameter int MAX_FALTAS = 3
) (
    input  logic clk,
    input  logic arst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic falla_o
);

    localparam int CW = $clog2(MAX_FALTAS + 1);
    localparam logic [CW-1:0] TOPE = CW'(MAX_FALTAS);

    logic [CW-1:0] cuenta_q, cuenta_d;
    logic          falla_q, falla_d;

    always_comb begin
        cuenta_d = cuenta_q;
        falla_d  = falla_q;
        if (clr_i) begin
            cuenta_d = '0;
            falla_d  = 1'b0;
        end else if (inc_i && (cuenta_q != TOPE)) begin
            cuenta_d = cuenta_q + 1'b1;
            falla_d  = (cuenta_d == TOPE);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cuenta_q <= '0;
            falla_q  <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            falla_q  <= falla_d;
        end
    end

    assign falla_o = falla_q;

endmodule

// File: rtl/planificador_sensores.sv
// rtl/planificador_sensores.sv - round-robin scan scheduler sharing one temperature datapath
// Purpose: every PERIODO idle cycles walks channels 0..N-1, forwards each valid sample to the
//   shared datapath, captures the returned alert LAT_RES cycles later and tracks missed scans.
// Ports:
//   clk, arst_n            : clock, synchronous active-low reset
//   habilitar              : scan enable
//   sensor_temp/valido     : packed samples and per-channel availability
//   sensor_ack             : one-hot consume pulse
//   temp_salida/valida     : sample to the datapath and its 1-cycle qualifier
//   canal_sel              : channel in service
//   alerta_in              : datapath alert, valid LAT_RES cycles after temp_valida
//   alerta_canal           : last captured alert per channel
//   sensor_falla           : missed-scan fault per channel
//   ronda_completa         : end-of-round pulse
//   ocupado                : scheduler inside a round
module planificador_sensores
    import pkg_monitoreo::*;
#(
    parameter int N_CANALES  = 4,
    parameter int ANCHO_TEMP = ANCHO_TEMP_DEF,
    parameter int PERIODO    = 1000,
    parameter int LAT_RES    = 2,
    parameter int MAX_FALTAS = 3
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              habilitar,
    input  logic [N_CANALES*ANCHO_TEMP-1:0]   sensor_temp,
    input  logic [N_CANALES-1:0]              sensor_valido,
    output logic [N_CANALES-1:0]              sensor_ack,
    output logic signed [ANCHO_TEMP-1:0]      temp_salida,
    output logic                              temp_valida,
    output logic [$clog2(N_CANALES)-1:0]      canal_sel,
    input  logic                              alerta_in,
    output logic [N_CANALES-1:0]              alerta_canal,
    output logic [N_CANALES-1:0]              sensor_falla,
    output logic                              ronda_completa,
    output logic                              ocupado
);

    localparam int CW_CANAL = $clog2(N_CANALES);
    localparam int MAX_CNT  = (PERIODO > LAT_RES) ? PERIODO : LAT_RES;
    localparam int CW_CNT   = $clog2(MAX_CNT + 1);

    estado_plan_t                  estado_q, estado_d;
    logic [CW_CNT-1:0]             cnt_q, cnt_d;
    logic [CW_CANAL-1:0]           canal_q, canal_d;
    logic signed [ANCHO_TEMP-1:0]  temp_q, temp_d;
    logic                          temp_valida_q, temp_valida_d;
    logic [N_CANALES-1:0]          ack_q, ack_d;
    logic [N_CANALES-1:0]          alerta_q, alerta_d;
    logic                          ronda_q, ronda_d;
    logic                          ocupado_q, ocupado_d;
    logic [N_CANALES-1:0]          inc_falta, clr_falta;

    logic                          valido_sel;
    logic                          ultimo;
    logic                          avanzar;
    logic signed [ANCHO_TEMP-1:0]  muestra;

    assign valido_sel = sensor_valido[canal_q];
    assign ultimo     = (canal_q == CW_CANAL'(N_CANALES - 1));
    assign muestra    = sensor_temp[canal_q*ANCHO_TEMP +: ANCHO_TEMP];
    // A channel is finished either when skipped in SELECCION or after its capture.
    assign avanzar    = ((estado_q == SELECCION) && !valido_sel) || (estado_q == CAPTURA);

    // State register
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            estado_q      <= REPOSO;
            cnt_q         <= '0;
            canal_q       <= '0;
            temp_q        <= '0;
            temp_valida_q <= 1'b0;
            ack_q         <= '0;
            alerta_q      <= '0;
            ronda_q       <= 1'b0;
            ocupado_q     <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            cnt_q         <= cnt_d;
            canal_q       <= canal_d;
            temp_q        <= temp_d;
            temp_valida_q <= temp_valida_d;
            ack_q         <= ack_d;
            alerta_q      <= alerta_d;
            ronda_q       <= ronda_d;
            ocupado_q     <= ocupado_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        canal_d  = canal_q;
        unique case (estado_q)
            REPOSO: begin
                if (habilitar) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end
            end
            ESPERA: begin
                if (!habilitar) begin
                    estado_d = REPOSO;
                end else if (cnt_q == CW_CNT'(PERIODO - 1)) begin
                    estado_d = SELECCION;
                    canal_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SELECCION: begin
                if (valido_sel) begin
                    estado_d = ENVIO;
                end
            end
            ENVIO: begin
                cnt_d    = '0;
                estado_d = (LAT_RES == 1) ? CAPTURA : ESPERA_RES;
            end
            ESPERA_RES: begin
                if (cnt_q == CW_CNT'(LAT_RES - 2)) begin
                    estado_d = CAPTURA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURA: begin
                estado_d = CAPTURA;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        // Dropping habilitar only takes effect at a channel boundary.
        if (avanzar) begin
            if (!habilitar) begin
                estado_d = REPOSO;
            end else if (ultimo) begin
                estado_d = ESPERA;
                cnt_d    = '0;
            end else begin
                estado_d = SELECCION;
                canal_d  = canal_q + 1'b1;
            end
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        temp_d        = temp_q;
        temp_valida_d = 1'b0;
        ack_d         = '0;
        alerta_d      = alerta_q;
        ronda_d       = 1'b0;
        inc_falta     = '0;
        clr_falta     = '0;
        ocupado_d     = (estado_d != REPOSO) && (estado_d != ESPERA);

        // Sample is latched here so later changes on the input cannot alter the channel in service.
        if (estado_q == SELECCION) begin
            if (valido_sel) begin
                temp_d             = muestra;
                temp_valida_d      = 1'b1;
                ack_d[canal_q]     = 1'b1;
                clr_falta[canal_q] = 1'b1;
            end else begin
                inc_falta[canal_q] = 1'b1;
            end
        end

        if (estado_q == CAPTURA) begin
            alerta_d[canal_q] = alerta_in;
        end

        if (avanzar && habilitar && ultimo) begin
            ronda_d = 1'b1;
        end
    end

    for (genvar g = 0; g < N_CANALES; g++) begin : g_faltas
        contador_faltas #(
            .MAX_FALTAS(MAX_FALTAS)
        ) u_contador (
            .clk    (clk),
            .arst_n (arst_n),
            .inc_i  (inc_falta[g]),
            .clr_i  (clr_falta[g]),
            .falla_o(sensor_falla[g])
        );
    end

    assign sensor_ack     = ack_q;
    assign temp_salida    = temp_q;
    assign temp_valida    = temp_valida_q;
    assign canal_sel      = canal_q;
    assign alerta_canal   = alerta_q;
    assign ronda_completa = ronda_q;
    assign ocupado        = ocupado_q;

endmodule

// File: tb/tb_planificador_sensores.sv
// tb/tb_planificador_sensores.sv - directed vector bench for the scan scheduler
module tb_planificador_sensores;

    localparam int N   = 4;
    localparam int W   = 11;
    localparam int PER = 4;
    localparam int LAT = 2;
    localparam int MXF = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  arst_n;
    logic                  habilitar;
    logic [N*W-1:0]        sensor_temp;
    logic [N-1:0]          sensor_valido;
    logic [N-1:0]          sensor_ack;
    logic signed [W-1:0]   temp_salida;
    logic                  temp_valida;
    logic [1:0]            canal_sel;
    logic                  alerta_in;
    logic [N-1:0]          alerta_canal;
    logic [N-1:0]          sensor_falla;
    logic                  ronda_completa;
    logic                  ocupado;

    int checks   = 0;
    int failures = 0;

    planificador_sensores #(
        .N_CANALES (N),
        .ANCHO_TEMP(W),
        .PERIODO   (PER),
        .LAT_RES   (LAT),
        .MAX_FALTAS(MXF)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .habilitar     (habilitar),
        .sensor_temp   (sensor_temp),
        .sensor_valido (sensor_valido),
        .sensor_ack    (sensor_ack),
        .temp_salida   (temp_salida),
        .temp_valida   (temp_valida),
        .canal_sel     (canal_sel),
        .alerta_in     (alerta_in),
        .alerta_canal  (alerta_canal),
        .sensor_falla  (sensor_falla),
        .ronda_completa(ronda_completa),
        .ocupado       (ocupado)
    );

    // Datapath model: alert when the sample exceeds 50, returned LAT cycles after temp_valida.
    logic [LAT-1:0] pipe = '0;
    always @(posedge clk) pipe <= {pipe[LAT-2:0], temp_valida && (temp_salida > 11'sd50)};
    assign alerta_in = pipe[LAT-1];

    typedef struct {
        logic         hab;
        logic [N-1:0] val;
        logic         tv;
        logic [W-1:0] temp;
        logic [N-1:0] ack;
        logic         rc;
        logic         ocup;
        logic [1:0]   canal;
    } vec_t;

    vec_t tabla[21];

    function automatic logic [W-1:0] t(input int v);
        return v[W-1:0];
    endfunction

    function automatic vec_t mk(input logic hab, input logic [N-1:0] val, input logic tv,
                                input int temp, input logic [N-1:0] ack, input logic rc,
                                input logic ocup, input int canal);
        vec_t r;
        r.hab = hab; r.val = val; r.tv = tv; r.temp = t(temp);
        r.ack = ack; r.rc = rc; r.ocup = ocup; r.canal = canal[1:0];
        return r;
    endfunction

    task automatic check(input string nombre, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nombre, act, exp);
        end
    endtask

    task automatic set_temp(input int ch, input int v);
        sensor_temp[ch*W +: W] = v[W-1:0];
    endtask

    task automatic wait_ronda(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ronda_completa && n < 200);
    endtask

    function automatic bit cond(input int m);
        case (m)
            0:       return canal_sel == 2'd1;
            1:       return sensor_ack == 4'b0010;
            2:       return sensor_ack == 4'b0001;
            default: return (canal_sel == 2'd0) && ocupado;
        endcase
    endfunction

    task automatic esperar(input int m, input string nombre);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(m) && n < 200);
        check(nombre, 64'(n < 200), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int extra;

        tabla[0]  = mk(1, 4'hF, 0,   0, 4'b0000, 0, 0, 0);
        tabla[1]  = mk(1, 4'hF, 0,   0, 4'b0000, 0, 0, 0);
        tabla[2]  = mk(1, 4'hF, 0,   0, 4'b0000, 0, 0, 0);
        tabla[3]  = mk(1, 4'hF, 0,   0, 4'b0000, 0, 0, 0);
        tabla[4]  = mk(1, 4'hF, 0,   0, 4'b0000, 0, 1, 0);
        tabla[5]  = mk(1, 4'hF, 1,  25, 4'b0001, 0, 1, 0);
        tabla[6]  = mk(1, 4'hF, 0,  25, 4'b0000, 0, 1, 0);
        tabla[7]  = mk(1, 4'hF, 0,  25, 4'b0000, 0, 1, 0);
        tabla[8]  = mk(1, 4'hF, 0,  25, 4'b0000, 0, 1, 1);
        tabla[9]  = mk(1, 4'hF, 1, -10, 4'b0010, 0, 1, 1);
        tabla[10] = mk(1, 4'hF, 0, -10, 4'b0000, 0, 1, 1);
        tabla[11] = mk(1, 4'hF, 0, -10, 4'b0000, 0, 1, 1);
        tabla[12] = mk(1, 4'hF, 0, -10, 4'b0000, 0, 1, 2);
        tabla[13] = mk(1, 4'hF, 1,  80, 4'b0100, 0, 1, 2);
        tabla[14] = mk(1, 4'hF, 0,  80, 4'b0000, 0, 1, 2);
        tabla[15] = mk(1, 4'hF, 0,  80, 4'b0000, 0, 1, 2);
        tabla[16] = mk(1, 4'hF, 0,  80, 4'b0000, 0, 1, 3);
        tabla[17] = mk(1, 4'hF, 1,  40, 4'b1000, 0, 1, 3);
        tabla[18] = mk(1, 4'hF, 0,  40, 4'b0000, 0, 1, 3);
        tabla[19] = mk(1, 4'hF, 0,  40, 4'b0000, 0, 1, 3);
        tabla[20] = mk(1, 4'b1101, 0, 40, 4'b0000, 1, 0, 3);

        arst_n        = 1'b0;
        habilitar     = 1'b0;
        sensor_valido = 4'hF;
        sensor_temp   = '0;
        set_temp(0, 25);
        set_temp(1, -10);
        set_temp(2, 80);
        set_temp(3, 40);
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({temp_valida, temp_salida, sensor_ack, canal_sel, alerta_canal,
                   sensor_falla, ronda_completa, ocupado}), 64'd0);
        arst_n    = 1'b1;
        habilitar = 1'b1;

        // Round 1: cycle-accurate table
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            check($sformatf("ronda1_ciclo%0d", i),
                  64'({temp_valida, temp_salida, sensor_ack, ronda_completa, ocupado, canal_sel}),
                  64'({tabla[i].tv, tabla[i].temp, tabla[i].ack, tabla[i].rc, tabla[i].ocup,
                       tabla[i].canal}));
            habilitar     = tabla[i].hab;
            sensor_valido = tabla[i].val;
        end
        check("alerta_ronda1", 64'(alerta_canal), 64'(4'b0100));
        check("falla_ronda1", 64'(sensor_falla), 64'(4'b0000));

        // Channel 1 missing for three rounds
        wait_ronda(n);
        check("gap_r2_salto", 64'(n), 64'd17);
        check("falla_r2", 64'(sensor_falla), 64'(4'b0000));
        wait_ronda(n);
        check("gap_r3_salto", 64'(n), 64'd17);
        check("falla_r3", 64'(sensor_falla), 64'(4'b0000));
        esperar(0, "espera_sel1_r4");
        check("falla_en_sel_r4", 64'(sensor_falla), 64'(4'b0000));
        @(negedge clk);
        check("falla_tras_sel_r4", 64'(sensor_falla), 64'(4'b0010));
        check("canal_tras_salto", 64'(canal_sel), 64'd2);
        wait_ronda(n);
        check("resto_r4", 64'(n), 64'd8);
        sensor_valido = 4'hF;

        // Good sample clears the fault in ENVIO
        esperar(0, "espera_sel1_r5");
        check("falla_sel_r5", 64'(sensor_falla), 64'(4'b0010));
        @(negedge clk);
        check("ack_envio_r5", 64'(sensor_ack), 64'(4'b0010));
        check("falla_envio_r5", 64'(sensor_falla), 64'(4'b0000));
        check("temp_envio_r5", 64'({temp_salida}), 64'(t(-10)));
        wait_ronda(n);
        check("resto_r5", 64'(n), 64'd11);

        // Sample latched in SELECCION; input changes in ENVIO ignored
        esperar(3, "espera_sel0_r6");
        @(negedge clk);
        sensor_valido[0] = 1'b0;
        set_temp(0, 99);
        #1;
        check("envio_latched", 64'({temp_valida, sensor_ack, temp_salida}),
              64'({1'b1, 4'b0001, t(25)}));
        @(negedge clk);
        check("espera_res_hold", 64'({temp_valida, temp_salida}), 64'({1'b0, t(25)}));
        sensor_valido = 4'hF;
        set_temp(0, 25);
        wait_ronda(n);
        check("alerta_r6", 64'(alerta_canal), 64'(4'b0100));
        set_temp(1, 70);

        // habilitar dropped during ESPERA_RES of channel 1
        esperar(1, "espera_ack1_r7");
        check("temp_ch1_r7", 64'({temp_salida}), 64'(t(70)));
        @(negedge clk);
        habilitar = 1'b0;
        @(negedge clk);
        check("ocupado_captura", 64'(ocupado), 64'd1);
        @(negedge clk);
        check("ocupado_reposo", 64'(ocupado), 64'd0);
        check("alerta_ch1_capturada", 64'(alerta_canal), 64'(4'b0110));
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sensor_ack != 4'b0000 || ronda_completa || ocupado) extra++;
        end
        check("sin_actividad_tras_baja", 64'(extra), 64'd0);

        // Reset during ENVIO
        set_temp(0, 90);
        habilitar = 1'b1;
        esperar(2, "espera_ack0_reset");
        arst_n = 1'b0;
        @(negedge clk);
        check("reset_en_envio",
              64'({temp_valida, temp_salida, sensor_ack, canal_sel, alerta_canal,
                   sensor_falla, ronda_completa, ocupado}), 64'd0);
        arst_n    = 1'b1;
        habilitar = 1'b0;
        repeat (4) @(negedge clk);
        check("alerta_sin_captura", 64'({alerta_canal, ocupado}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
